conf_fetch: RTL and testbench

- Upstream stage of the control/execution unit: fetches configuration lines from host memory and buffers them.
- Presents lines to the configuration reader over the available_read / rd_data / req_rd_data handshake.
- Generates sequential line addresses from a base address and a line count.
- Throttles requests by credit so responses, which cannot be back-pressured, never overflow the buffer.

---
 rtl/conf_fetch_pkg.sv | 30 +++
 rtl/conf_fetch_if.sv | 33 +++
 rtl/conf_fetch_fifo_fwft.sv | 68 ++++++
 rtl/conf_fetch.sv | 161 ++++++++++++++++
 tb/tb_conf_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conf_fetch_pkg.sv
// Shared definitions for the configuration fetch stage: default widths,
// FSM state encoding and the request-credit helper.
package conf_fetch_pkg;

    // Default widths; modules expose them as overridable parameters.
    localparam int DEF_DATA_WIDTH     = 512;
    localparam int DEF_ADDR_WIDTH     = 64;
    localparam int DEF_FIFO_DEPTH_LOG = 4;

    // Bytes per memory line at the default data width.
    localparam int LINE_BYTES = DEF_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when one more request still has a guaranteed landing slot:
    // lines in flight plus lines already buffered must stay below depth.
    function automatic logic has_credit(input logic [31:0] outstanding,
                                        input logic [31:0] buffered,
                                        input int unsigned depth_log);
        logic [32:0] used;
        used = {1'b0, outstanding} + {1'b0, buffered};
        return used < (33'd1 << depth_log);
    endfunction

endpackage

// File: rtl/conf_fetch_if.sv
// Memory-side bus of the configuration fetch stage: a valid/ready read
// request channel and an in-order response channel with no back-pressure.
interface conf_fetch_if
    import conf_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    // Fetch unit side: issues requests, consumes responses.
    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface

// File: rtl/conf_fetch_fifo_fwft.sv
// First-word-fall-through line buffer: the head entry is visible on rd_data
// whenever the buffer is non-empty; pop advances to the next entry.
module fifo_fwft #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH_LOG:0]    count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]   FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   ONE_COUNT  = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] ONE_PTR    = DEPTH_LOG'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG-1:0]  wr_ptr;
    logic [DEPTH_LOG-1:0]  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; only pointers and count do, and
    // the head is masked to zero while empty so stale contents never leak.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Write the incoming line into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Advance pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conf_fetch.sv
// Configuration fetch stage: walks a run of memory lines from a base
// address, throttles requests by buffer credit, and presents the returned
// lines to the configuration reader through a first-word-fall-through FIFO.
module conf_fetch
    import conf_fetch_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH_LOG = DEF_FIFO_DEPTH_LOG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           num_lines,
    conf_fetch_if.master          mem,
    output logic                  available_read,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  req_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0]   LINE_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [FIFO_DEPTH_LOG:0] ONE_COUNT = (FIFO_DEPTH_LOG + 1)'(1);

    state_t                  state;
    logic [31:0]             num_q;
    logic [31:0]             issued;
    logic [31:0]             received;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    req_valid;

    logic [FIFO_DEPTH_LOG:0] fifo_count;
    logic [FIFO_DEPTH_LOG:0] fifo_count_next;
    logic                    fifo_empty;
    logic                    fifo_full;

    logic                    in_run;
    logic                    xfer;
    logic                    accept;
    logic                    drop;
    logic                    pop;
    logic [31:0]             issued_next;
    logic [31:0]             received_next;
    logic                    credit_next;

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_addr  = addr_q;
    assign available_read    = !fifo_empty;

    // Lookahead of this cycle's handshakes so the registered request valid
    // already reflects credit freed or consumed at this edge.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no path
        // through this block can leave one unassigned and infer a latch.
        in_run          = (state == FETCH) || (state == DRAIN);
        xfer            = req_valid && mem.mem_req_ready;
        accept          = mem.mem_resp_valid && in_run && (received < num_q) && !fifo_full;
        drop            = mem.mem_resp_valid && in_run && !accept;
        pop             = req_rd_data && !fifo_empty;
        issued_next     = issued + 32'(xfer);
        received_next   = received + 32'(accept);
        fifo_count_next = fifo_count;
        if (accept && !pop) begin
            fifo_count_next = fifo_count + ONE_COUNT;
        end else if (!accept && pop) begin
            fifo_count_next = fifo_count - ONE_COUNT;
        end
        credit_next = has_credit(issued_next - received_next,
                                 32'(fifo_count_next), FIFO_DEPTH_LOG);
    end

    // Fetch sequencer with registered request, busy, done and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            num_q     <= '0;
            issued    <= '0;
            received  <= '0;
            addr_q    <= '0;
            req_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_q    <= num_lines;
                        issued   <= '0;
                        received <= '0;
                        addr_q   <= base_addr;
                        err      <= 1'b0;
                        if (num_lines == '0) begin
                            state     <= DONE;
                            req_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            // The buffer is always empty outside a run, so
                            // the first request has credit unconditionally.
                            state     <= FETCH;
                            req_valid <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    issued   <= issued_next;
                    received <= received_next;
                    if (xfer) begin
                        addr_q <= addr_q + LINE_STEP;
                    end
                    if (drop) begin
                        err <= 1'b1;
                    end
                    if (issued_next == num_q) begin
                        state     <= DRAIN;
                        req_valid <= 1'b0;
                    end else begin
                        // Credit never shrinks without a transfer, so a
                        // stalled request stays asserted with a fixed address.
                        req_valid <= credit_next;
                    end
                end
                DRAIN: begin
                    received <= received_next;
                    if (drop) begin
                        err <= 1'b1;
                    end
                    if ((received == num_q) && (fifo_count == '0)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffer between memory responses and the configuration reader.
    fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG  (FIFO_DEPTH_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data (mem.mem_resp_data),
        .pop     (pop),
        .rd_data (rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_conf_fetch.sv
// Self-checking bench for conf_fetch: an in-order memory model, a consumer
// model, and scoreboard queues of expected addresses and lines.
module tb_conf_fetch;
    import conf_fetch_pkg::*;

    localparam int DW = 512;
    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [31:0]   num_lines;
    logic          req_rd_data;
    logic          available_read;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err;

    conf_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

    conf_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH_LOG(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .num_lines      (num_lines),
        .mem            (mem_if),
        .available_read (available_read),
        .rd_data        (rd_data),
        .req_rd_data    (req_rd_data),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         pend[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int last_due    = 0;
    int lat         = 2;
    int req_count   = 0;
    int pop_count   = 0;
    int valid_cycles = 0;
    bit rand_mode   = 1'b0;
    bit ready_fixed = 1'b1;
    bit pop_fixed   = 1'b0;
    bit inject_extra = 1'b0;
    bit prev_stall  = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {8{a ^ 64'hC3C3_0000_5A5A_0000}};
    endfunction

    // Memory responses and consumer/ready stimulus, driven just after each edge.
    initial begin
        mem_if.mem_req_ready  = 1'b1;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = '0;
        req_rd_data           = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_if.mem_resp_valid = 1'b1;
                mem_if.mem_resp_data  = pend[0].data;
                void'(pend.pop_front());
            end else if (inject_extra && pend.size() == 0) begin
                mem_if.mem_resp_valid = 1'b1;
                mem_if.mem_resp_data  = {16{32'hDEAD_BEEF}};
                inject_extra          = 1'b0;
            end else begin
                mem_if.mem_resp_valid = 1'b0;
            end
            mem_if.mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
            req_rd_data          = rand_mode ? 1'($urandom_range(0, 1)) : pop_fixed;
        end
    end

    // Monitor: sample mid-cycle, score requests and pops against the plan.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", DW'(mem_if.mem_req_valid), DW'(1'b1));
                    check("hold_addr", DW'(mem_if.mem_req_addr), DW'(prev_addr));
                end
                if (mem_if.mem_req_valid) valid_cycles++;
                if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
                    int due;
                    req_count++;
                    check("req_in_plan", DW'(exp_addr.size() > 0), DW'(1'b1));
                    if (exp_addr.size() > 0) begin
                        check("req_addr", DW'(mem_if.mem_req_addr), DW'(exp_addr.pop_front()));
                    end
                    due = cyc + 1 + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend.push_back('{due: due, data: line_of(mem_if.mem_req_addr)});
                end
                if (available_read && req_rd_data) begin
                    pop_count++;
                    check("pop_in_plan", DW'(exp_data.size() > 0), DW'(1'b1));
                    if (exp_data.size() > 0) begin
                        check("rd_data", rd_data, exp_data.pop_front());
                    end
                end
                prev_stall = mem_if.mem_req_valid && !mem_if.mem_req_ready;
                prev_addr  = mem_if.mem_req_addr;
            end
        end
    end

    task automatic start_fetch(input logic [AW-1:0] b, input logic [31:0] n);
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            a = b + 64'(i) * 64'(LINE_BYTES);
            exp_addr.push_back(a);
            exp_data.push_back(line_of(a));
        end
        req_count = 0;
        pop_count = 0;
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = b;
        num_lines = n;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, DW'(done), DW'(1'b1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, DW'(mem_if.mem_req_valid), '0);
        check({tag, "_addr"}, DW'(mem_if.mem_req_addr), '0);
        check({tag, "_avail"}, DW'(available_read), '0);
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
        check({tag, "_err"}, DW'(err), '0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_lines = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Zero-length fetch completes immediately without requests.
        valid_cycles = 0;
        start_fetch(64'h0, 32'd0);
        @(negedge clk);
        check("zero_done", DW'(done), DW'(1'b1));
        check("zero_busy", DW'(busy), '0);
        repeat (5) @(negedge clk);
        check("zero_no_req", DW'(valid_cycles), '0);
        check("zero_avail", DW'(available_read), '0);

        // Basic four-line fetch with continuous consumption.
        lat = 2; ready_fixed = 1'b1; pop_fixed = 1'b1;
        start_fetch(64'h1000, 32'd4);
        @(negedge clk);
        check("first_req_valid", DW'(mem_if.mem_req_valid), DW'(1'b1));
        check("first_req_addr", DW'(mem_if.mem_req_addr), DW'(64'h1000));
        wait_done("basic_done", 100);
        check("basic_err", DW'(err), '0);
        check("basic_reqs", DW'(req_count), DW'(4));
        check("basic_pops", DW'(pop_count), DW'(4));
        check("basic_busy", DW'(busy), '0);

        // Credit limit: no consumer means exactly a buffer's worth of requests.
        pop_fixed = 1'b0;
        start_fetch(64'h2000_0000, 32'd40);
        repeat (60) @(negedge clk);
        check("credit_reqs", DW'(req_count), DW'(16));
        check("credit_avail", DW'(available_read), DW'(1'b1));
        check("credit_busy", DW'(busy), DW'(1'b1));
        pop_fixed = 1'b1;
        wait_done("credit_done", 600);
        check("credit_reqs_all", DW'(req_count), DW'(40));
        check("credit_pops_all", DW'(pop_count), DW'(40));
        check("credit_left", DW'(exp_data.size()), '0);

        // Address wrap at the top of the address space.
        start_fetch(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
        wait_done("wrap_done", 100);
        check("wrap_reqs", DW'(req_count), DW'(2));

        // Random ready and consumer back-pressure.
        lat = 3; rand_mode = 1'b1;
        start_fetch(64'h4000, 32'd30);
        wait_done("rand_done", 3000);
        rand_mode = 1'b0;
        check("rand_reqs", DW'(req_count), DW'(30));
        check("rand_pops", DW'(pop_count), DW'(30));
        check("rand_left", DW'(exp_addr.size() + exp_data.size()), '0);
        check("rand_err", DW'(err), '0);

        // Unexpected extra response while still draining.
        lat = 2; ready_fixed = 1'b1; pop_fixed = 1'b0;
        start_fetch(64'h8000, 32'd3);
        repeat (15) @(negedge clk);
        check("extra_pre_busy", DW'(busy), DW'(1'b1));
        check("extra_pre_err", DW'(err), '0);
        inject_extra = 1'b1;
        repeat (4) @(negedge clk);
        check("extra_err", DW'(err), DW'(1'b1));
        check("extra_busy", DW'(busy), DW'(1'b1));
        pop_fixed = 1'b1;
        wait_done("extra_done", 100);
        check("extra_pops", DW'(pop_count), DW'(3));
        check("extra_avail", DW'(available_read), '0);
        check("extra_err_sticky", DW'(err), DW'(1'b1));

        // Reset with three requests in flight; late responses must be ignored.
        lat = 10; pop_fixed = 1'b0;
        start_fetch(64'hA000, 32'd3);
        @(negedge clk);
        check("rst_start_clears_err", DW'(err), '0);
        begin
            int k = 0;
            while (req_count < 3 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("rst_reqs", DW'(req_count), DW'(3));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        repeat (20) @(negedge clk);
        check("late_err", DW'(err), '0);
        check("late_avail", DW'(available_read), '0);
        check("late_busy", DW'(busy), '0);
        check("late_done", DW'(done), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
